// File: rtl/alu_mcycle_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mcycle_seq_pkg
//  Purpose  : Shared definitions for the multi-cycle MUL/DIV sequencer:
//             sequencer state encoding, MCycleOp codes, the ALU operation
//             codes it borrows and the position of the carry flag.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package alu_mcycle_seq_pkg;

    // FIX is only reachable when MCYCLE_SIGNED_EN is defined.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mc_state_t;

    localparam logic       c_OP_MUL   = 1'b0;
    localparam logic       c_OP_DIV   = 1'b1;

    localparam logic [1:0] c_ALU_ADD  = 2'b00;
    localparam logic [1:0] c_ALU_SUB  = 2'b01;

    // ALU_Flags is {N,Z,C,V}; for SUB the ALU reports C=1 when no borrow.
    localparam int         c_FLAG_C   = 1;

endpackage
`default_nettype wire

// File: rtl/alu_mcycle_mux.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mcycle_mux
//  Purpose  : Combinational arbiter for the shared ALU inputs. While the
//             sequencer is iterating it owns the ALU; otherwise the pipeline
//             operands pass straight through.
//  Ports    : i_seq_sel              - 1: sequencer drives the ALU
//             i_seq_src_a/b, i_seq_ctrl    - sequencer operands / op
//             i_pipe_src_a/b, i_pipe_ctrl  - pipeline operands / op
//             o_alu_src_a/b, o_alu_ctrl    - to the ALU
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mcycle_mux #(
    parameter int WIDTH = 32
) (
    input  logic             i_seq_sel,
    input  logic [WIDTH-1:0] i_seq_src_a,
    input  logic [WIDTH-1:0] i_seq_src_b,
    input  logic [1:0]       i_seq_ctrl,
    input  logic [WIDTH-1:0] i_pipe_src_a,
    input  logic [WIDTH-1:0] i_pipe_src_b,
    input  logic [1:0]       i_pipe_ctrl,
    output logic [WIDTH-1:0] o_alu_src_a,
    output logic [WIDTH-1:0] o_alu_src_b,
    output logic [1:0]       o_alu_ctrl
);

    assign o_alu_src_a = i_seq_sel ? i_seq_src_a : i_pipe_src_a;
    assign o_alu_src_b = i_seq_sel ? i_seq_src_b : i_pipe_src_b;
    assign o_alu_ctrl  = i_seq_sel ? i_seq_ctrl  : i_pipe_ctrl;

endmodule
`default_nettype wire

// File: rtl/alu_mcycle_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mcycle_seq
//  Purpose  : Multi-cycle MUL/DIV sequencer. Borrows the shared ALU adder to
//             run a WIDTH-step shift-add multiply or restoring divide and
//             stalls the pipeline via Busy while doing so.
//  Ports    : CLK, RESETn (async, active low)
//             Start, MCycleOp (0 MUL / 1 DIV), Signed, Operand1, Operand2
//             Busy, Done, Result1 (lo / quotient), Result2 (hi / remainder)
//             Pipe_Src_A/B, Pipe_ALUControl  - pipeline ALU request
//             ALU_Src_A/B, ALU_ALUControl    - to the shared ALU
//             ALU_Result, ALU_Flags {N,Z,C,V} - from the shared ALU
//  Config   : MCYCLE_SIGNED_EN - signed operations via a trailing FIX cycle
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mcycle_seq
    import alu_mcycle_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    input  logic [WIDTH-1:0] Pipe_Src_A,
    input  logic [WIDTH-1:0] Pipe_Src_B,
    input  logic [1:0]       Pipe_ALUControl,
    output logic [WIDTH-1:0] ALU_Src_A,
    output logic [WIDTH-1:0] ALU_Src_B,
    output logic [1:0]       ALU_ALUControl,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic [3:0]       ALU_Flags
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    mc_state_t        r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_hi;      // MUL: product high / DIV: partial remainder
    logic [WIDTH-1:0] r_lo;      // MUL: multiplier+product low / DIV: quotient
    logic [WIDTH-1:0] r_opnd;    // multiplicand or divisor, fixed for the run
    logic [WIDTH-1:0] r_res1, r_res2;

    logic [WIDTH-1:0] w_op1, w_op2;
    logic             w_need_fix;
    logic             w_carry;
    logic [WIDTH:0]   w_rprime;
    logic [WIDTH-1:0] w_seq_a, w_hi_nxt, w_lo_nxt;
    logic [1:0]       w_seq_ctrl;

`ifdef MCYCLE_SIGNED_EN
    logic             r_sgn, r_neg_a, r_neg_b;
    logic [WIDTH-1:0] w_fix_res1, w_fix_res2;
    logic [2*WIDTH-1:0] w_prod_neg;
    logic             w_unused_flags;

    // The core is unsigned: strip signs at latch time, restore them in FIX.
    assign w_op1      = (Signed && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
    assign w_op2      = (Signed && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
    assign w_need_fix = r_sgn;
    assign w_prod_neg = -{r_hi, r_lo};

    always_comb begin
        w_fix_res1 = r_lo;
        w_fix_res2 = r_hi;
        if (r_op == c_OP_MUL) begin
            if (r_neg_a ^ r_neg_b) begin
                {w_fix_res2, w_fix_res1} = w_prod_neg;
            end
        end else begin
            // Truncating division: quotient sign from the operand signs,
            // remainder takes the dividend's sign.
            if (r_neg_a ^ r_neg_b) w_fix_res1 = -r_lo;
            if (r_neg_a)           w_fix_res2 = -r_hi;
        end
    end

    assign w_unused_flags = ^{ALU_Flags[3:2], ALU_Flags[0]};
`else
    logic w_unused_inputs;

    assign w_op1      = Operand1;
    assign w_op2      = Operand2;
    assign w_need_fix = 1'b0;
    assign w_unused_inputs = ^{Signed, ALU_Flags[3:2], ALU_Flags[0]};
`endif

    // One iteration step, computed from the ALU's answer this cycle.
    always_comb begin
        w_carry    = ALU_Flags[c_FLAG_C];
        w_rprime   = {r_hi, r_lo[WIDTH-1]};
        w_seq_a    = r_hi;
        w_seq_ctrl = c_ALU_ADD;
        w_hi_nxt   = r_hi;
        w_lo_nxt   = r_lo;
        if (r_op == c_OP_DIV) begin
            w_seq_a    = w_rprime[WIDTH-1:0];
            w_seq_ctrl = c_ALU_SUB;
            // The bit shifted out of R' means R' >= divisor regardless of
            // what the WIDTH-bit subtract reports.
            if (w_rprime[WIDTH] || w_carry) begin
                w_hi_nxt = ALU_Result;
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_rprime[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (r_lo[0]) begin
                w_hi_nxt = {w_carry, ALU_Result[WIDTH-1:1]};
                w_lo_nxt = {ALU_Result[0], r_lo[WIDTH-1:1]};
            end else begin
                w_hi_nxt = {1'b0, r_hi[WIDTH-1:1]};
                w_lo_nxt = {r_hi[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_next_state = S_RUN;
            S_RUN:   if (r_cnt == '0) w_next_state = w_need_fix ? S_FIX : S_DONE;
            S_FIX:   w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= c_OP_MUL;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_res1  <= '0;
            r_res2  <= '0;
`ifdef MCYCLE_SIGNED_EN
            r_sgn   <= 1'b0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_op   <= MCycleOp;
                        r_cnt  <= c_CNT_LAST;
                        r_hi   <= '0;
                        r_lo   <= (MCycleOp == c_OP_DIV) ? w_op1 : w_op2;
                        r_opnd <= (MCycleOp == c_OP_DIV) ? w_op2 : w_op1;
`ifdef MCYCLE_SIGNED_EN
                        r_sgn   <= Signed;
                        r_neg_a <= Signed & Operand1[WIDTH-1];
                        r_neg_b <= Signed & Operand2[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    // Results land with the final step so they are valid in DONE.
                    if (r_cnt == '0 && !w_need_fix) begin
                        r_res1 <= w_lo_nxt;
                        r_res2 <= w_hi_nxt;
                    end
                end
`ifdef MCYCLE_SIGNED_EN
                S_FIX: begin
                    r_res1 <= w_fix_res1;
                    r_res2 <= w_fix_res2;
                end
`endif
                default: ;
            endcase
        end
    end

    assign Busy    = (r_state != S_IDLE);
    assign Done    = (r_state == S_DONE);
    assign Result1 = r_res1;
    assign Result2 = r_res2;

    alu_mcycle_mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_seq_sel    (r_state == S_RUN),
        .i_seq_src_a  (w_seq_a),
        .i_seq_src_b  (r_opnd),
        .i_seq_ctrl   (w_seq_ctrl),
        .i_pipe_src_a (Pipe_Src_A),
        .i_pipe_src_b (Pipe_Src_B),
        .i_pipe_ctrl  (Pipe_ALUControl),
        .o_alu_src_a  (ALU_Src_A),
        .o_alu_src_b  (ALU_Src_B),
        .o_alu_ctrl   (ALU_ALUControl)
    );

endmodule
`default_nettype wire

// File: doc/alu_mcycle_seq.md
Name: alu_mcycle_seq

Overview:
Multi-cycle MUL/DIV sequencer that borrows the shared 32-bit ALU adder to run iterative shift-add multiply and restoring divide. It sits beside the ALU in the execute stage and arbitrates ALU inputs between the pipeline (pass-through) and itself while busy. It stalls the pipeline via Busy and returns a 64-bit product or a quotient/remainder pair.

Parameters:
WIDTH, 32, operand width; equals ALU datapath width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  input  1  system clock, rising edge
RESETn  input  1  asynchronous active-low reset
Start  input  1  launch request; sampled in IDLE only
MCycleOp  input  1  0 = multiply, 1 = divide
Signed  input  1  signed operation; used only when MCYCLE_SIGNED_EN is defined
Operand1  input  WIDTH  multiplicand / dividend
Operand2  input  WIDTH  multiplier / divisor
Busy  output  1  high from the cycle after Start is accepted until Done; pipeline stall
Done  output  1  one-cycle pulse; results valid from this cycle
Result1  output  WIDTH  MUL: product[31:0]; DIV: quotient
Result2  output  WIDTH  MUL: product[63:32]; DIV: remainder
Pipe_Src_A  input  WIDTH  pipeline ALU operand A
Pipe_Src_B  input  WIDTH  pipeline ALU operand B
Pipe_ALUControl  input  2  pipeline ALU op
ALU_Src_A  output  WIDTH  to ALU Src_A
ALU_Src_B  output  WIDTH  to ALU Src_B
ALU_ALUControl  output  2  to ALU ALUControl
ALU_Result  input  WIDTH  from ALU ALUResult
ALU_Flags  input  4  from ALU {N,Z,C,V}

Behaviour:
- Reset (async, RESETn=0): state=IDLE; Busy=0; Done=0; Result1=Result2=0; counter=0; internal registers cleared. Reset mid-operation aborts and drops Busy immediately.
- States: IDLE -> RUN on Start; RUN -> DONE after WIDTH iterations (counter WIDTH-1 down to 0); DONE -> IDLE unconditionally. With MCYCLE_SIGNED_EN: RUN -> FIX -> DONE when Signed=1.
- Arbitration: in IDLE and DONE, ALU_* = Pipe_* combinationally. In RUN, ALU_* driven by the sequencer and pipeline inputs ignored. No cycle where both drive.
- Start in IDLE latches operands; Start while Busy is ignored; Start in the DONE cycle is ignored (must be reasserted in IDLE).
- MUL: Hi=0, Lo=Operand2. Each RUN cycle ALU_ALUControl=00, Src_A=Hi, Src_B=multiplicand. If Lo[0]=1: {Hi,Lo} <= {C,ALU_Result,Lo} >> 1 using C=ALU_Flags[1]; else {Hi,Lo} <= {1'b0,Hi,Lo} >> 1.
- DIV (restoring): R=0, Q=Operand1. Each RUN cycle form R'={R,Q[WIDTH-1]} (WIDTH+1 bits); ALU_ALUControl=01, Src_A=R'[WIDTH-1:0], Src_B=divisor. If R'[WIDTH]=1 or C=1 (no borrow): R<=ALU_Result, Q<={Q[WIDTH-2:0],1}; else R<=R'[WIDTH-1:0], Q<={Q[WIDTH-2:0],0}.
- Divide by zero: no trap; quotient=all ones, remainder=dividend (natural algorithm result, must hold).
- Latency: Start high in IDLE at cycle 0 -> Busy high cycles 1..WIDTH+1 -> Done high cycle WIDTH+1 (+1 with FIX). Result1/2 registered, hold until next accepted Start.
- ALU_Flags[3:2,0] unused by the sequencer.

Optional Feature:
MCYCLE_SIGNED_EN. Defined: Signed=1 takes absolute values at operand latch, runs unsigned core, then a FIX cycle negates results. MUL negates the 64-bit product if sign differs. DIV negates quotient if signs differ and negates remainder if dividend negative. Latency +1. Undefined: Signed ignored, no FIX state, all ops unsigned.

Decomposition:
- Shared package: state encoding (IDLE/RUN/FIX/DONE), MCycleOp codes, ALUControl constants ADD=2'b00 and SUB=2'b01, C flag index=1.
- One sub-module: alu_mcycle_mux, the combinational ALU input arbiter selected by the sequencer's own flag.

Test Plan:
- MUL 7 x 6 -> Done at cycle 33, Result1=42, Result2=0; Busy high exactly 33 cycles.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> Result2=0xFFFFFFFE, Result1=0x00000001 (carry path exercised).
- DIV 100 / 7 -> quotient 14, remainder 2; DIV 0xFFFFFFFF / 0x80000001 -> quotient 1, remainder 0x7FFFFFFE (R'[32] path).
- DIV 5 / 0 -> quotient 0xFFFFFFFF, remainder 5.
- Pipe_Src_A=3, Pipe_Src_B=4, Pipe_ALUControl=00 in IDLE -> ALU_* equal Pipe_*; during RUN -> ALU_* independent of Pipe_*. Start pulsed mid-RUN has no effect.
- RESETn low at iteration 10 -> Busy=0, Done=0, results 0 immediately. With MCYCLE_SIGNED_EN: signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, Done at cycle 34.
